// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic single-transfer master bridging a valid/ready request/response pair.
// Optional bus timeout is compiled in with `define WB_INITIATOR_TIMEOUT_EN.
module wb_initiator #(
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_adr_i,
  input  logic        req_we_i,
  input  logic [3:0]  req_sel_i,
  input  logic [31:0] req_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  output logic        we_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);
  localparam int RW = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, BACKOFF = 2'd2, RESP = 2'd3;
  logic [1:0]  state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic        cyc_q, cyc_d;
  logic [31:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [RW-1:0] retry_q, retry_d;
  logic        done;
`ifdef WB_INITIATOR_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        rsp_tmo_q, rsp_tmo_d;
  assign rsp_timeout_o = rsp_tmo_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif
  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign adr_o       = adr_q;
  assign sel_o       = sel_q;
  assign dat_o       = dat_q;
  assign we_o        = we_q;
  // Next-state logic: accept, drive the bus, resolve termination (ack > err > rty > timeout), respond.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cyc_d       = cyc_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    we_d        = we_q;
    retry_d     = retry_q;
    done        = 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
    tmo_d       = tmo_q;
    rsp_tmo_d   = rsp_tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          state_d     = BUS;
          req_ready_d = 1'b0;
          cyc_d       = 1'b1;
          adr_d       = req_adr_i;
          sel_d       = req_sel_i;
          we_d        = req_we_i;
          dat_d       = req_we_i ? req_dat_i : '0;
          retry_d     = '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
          tmo_d       = '0;
`endif
        end else begin
          req_ready_d = 1'b1;
        end
      end
      BUS: begin
`ifdef WB_INITIATOR_TIMEOUT_EN
        rsp_tmo_d = 1'b0;
`endif
        if (ack_i) begin
          done      = 1'b1;
          rsp_err_d = 1'b0;
          rsp_dat_d = we_q ? '0 : dat_i;
        end else if (err_i || (rty_i && retry_q == RW'(MAX_RETRIES))) begin
          done      = 1'b1;
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
        end else if (rty_i) begin
          retry_d = retry_q + 1'b1;
          cyc_d   = 1'b0;
          state_d = BACKOFF;
        end
`ifdef WB_INITIATOR_TIMEOUT_EN
        else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
          done      = 1'b1;
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
          rsp_tmo_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      BACKOFF: begin
        cyc_d   = 1'b1;
        state_d = BUS;
`ifdef WB_INITIATOR_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      default: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
    if (done) begin
      state_d     = RESP;
      rsp_valid_d = 1'b1;
      cyc_d       = 1'b0;
      adr_d       = '0;
      sel_d       = '0;
      dat_d       = '0;
      we_d        = 1'b0;
    end
  end
  // State and registered outputs; async reset drops the bus cycle immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      retry_q     <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
      tmo_q       <= '0;
      rsp_tmo_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cyc_q       <= cyc_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      retry_q     <= retry_d;
`ifdef WB_INITIATOR_TIMEOUT_EN
      tmo_q       <= tmo_d;
      rsp_tmo_q   <= rsp_tmo_d;
`endif
    end
  end
endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: directed bench for wb_initiator with a scripted Wishbone responder.
module tb_wb_initiator;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        req_valid_i, req_ready_o, req_we_i, rsp_valid_o, rsp_ready_i;
  logic [31:0] req_adr_i, req_dat_i, rsp_dat_o, adr_o, dat_o, dat_i;
  logic [3:0]  req_sel_i, sel_o;
  logic        rsp_err_o, rsp_timeout_o, cyc_o, stb_o, we_o, ack_i, err_i, rty_i;
  int          n_tests = 0, n_fail = 0;
  int          mode, rty_n, nstb, stb_cyc, lat;
  logic        stb_prev, hold_bad;
  logic [31:0] rd_dat;

  wb_initiator #(.MAX_RETRIES(3), .TIMEOUT_CYCLES(10)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_adr_i(req_adr_i),
    .req_we_i(req_we_i), .req_sel_i(req_sel_i), .req_dat_i(req_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o), .we_o(we_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, tally strobes, and answer any strobe per the current mode.
  task automatic tick();
    @(negedge clk_i);
    if (stb_o && !stb_prev) nstb++;
    if (stb_o) stb_cyc++;
    stb_prev = stb_o;
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = '0;
    if (stb_o) begin
      dat_i = rd_dat;
      case (mode)
        0: ack_i = 1'b1;
        1: err_i = 1'b1;
        2: if (nstb > rty_n) ack_i = 1'b1; else rty_i = 1'b1;
        4: begin ack_i = 1'b1; err_i = 1'b1; rty_i = 1'b1; end
        5: begin err_i = 1'b1; rty_i = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input int budget);
    nstb = 0; stb_cyc = 0; lat = 0; hold_bad = 1'b0;
    req_valid_i = 1'b1; req_we_i = we; req_adr_i = adr; req_sel_i = sel; req_dat_i = dat;
    tick();
    req_valid_i = 1'b0;
    check("cyc_on_accept", {31'd0, cyc_o}, 32'd1);
    check("adr_o", adr_o, adr);
    check("dat_o", dat_o, we ? dat : 32'd0);
    while (!rsp_valid_o && lat < budget) begin
      if (stb_o && (adr_o !== adr || sel_o !== sel || we_o !== we || dat_o !== (we ? dat : 32'd0)))
        hold_bad = 1'b1;
      if (req_ready_o) hold_bad = 1'b1;
      tick();
      lat++;
    end
    check("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    check("bus_hold", {31'd0, hold_bad}, 32'd0);
  endtask

  task automatic finish_rsp();
    check("ready_in_resp", {31'd0, req_ready_o}, 32'd0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("rsp_drop", {31'd0, rsp_valid_o}, 32'd0);
    check("ready_after", {31'd0, req_ready_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_valid_i = 0; req_we_i = 0; req_adr_i = 0; req_sel_i = 0; req_dat_i = 0;
    rsp_ready_i = 0; dat_i = 0; ack_i = 0; err_i = 0; rty_i = 0;
    mode = 0; rty_n = 0; rd_dat = 0; stb_prev = 0; nstb = 0; stb_cyc = 0; lat = 0;
    #1;
    check("rst_cyc", {31'd0, cyc_o}, 32'd0);
    check("rst_ready", {31'd0, req_ready_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_adr", adr_o, 32'd0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    check("ready_post_rst", {31'd0, req_ready_o}, 32'd1);
    // Terminations outside BUS are ignored
    ack_i = 1'b1; err_i = 1'b1; rty_i = 1'b1;
    @(negedge clk_i);
    check("idle_term_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("idle_term_ready", {31'd0, req_ready_o}, 32'd1);
    tick();
    // Read with one-cycle ack
    mode = 0; rd_dat = 32'hDEADBEEF;
    xfer(1'b0, 32'h80000008, 4'hF, 32'h0, 20);
    check("rd_lat", lat, 1); check("rd_nstb", nstb, 1);
    check("rd_dat", rsp_dat_o, 32'hDEADBEEF); check("rd_err", {31'd0, rsp_err_o}, 32'd0);
    finish_rsp();
    // Write: response data must be 0 even though dat_i is nonzero
    rd_dat = 32'hFFFFFFFF;
    xfer(1'b1, 32'h80000004, 4'b0011, 32'h1234ABCD, 20);
    check("wr_sel_lat", lat, 1);
    check("wr_dat", rsp_dat_o, 32'h0); check("wr_err", {31'd0, rsp_err_o}, 32'd0);
    finish_rsp();
    // Two retries then ack
    mode = 2; rty_n = 2; rd_dat = 32'hCAFEF00D;
    xfer(1'b0, 32'h00000010, 4'hF, 32'h0, 30);
    check("rty2_nstb", nstb, 3); check("rty2_stbcyc", stb_cyc, 3); check("rty2_lat", lat, 5);
    check("rty2_dat", rsp_dat_o, 32'hCAFEF00D); check("rty2_err", {31'd0, rsp_err_o}, 32'd0);
    finish_rsp();
    // Retries exhausted
    rty_n = 99;
    xfer(1'b0, 32'h00000014, 4'hF, 32'h0, 30);
    check("rtyx_nstb", nstb, 4); check("rtyx_lat", lat, 7);
    check("rtyx_err", {31'd0, rsp_err_o}, 32'd1); check("rtyx_tmo", {31'd0, rsp_timeout_o}, 32'd0);
    check("rtyx_dat", rsp_dat_o, 32'h0);
    finish_rsp();
    // Error termination
    mode = 1; rd_dat = 32'h55555555;
    xfer(1'b0, 32'h00000018, 4'hF, 32'h0, 20);
    check("err_err", {31'd0, rsp_err_o}, 32'd1); check("err_dat", rsp_dat_o, 32'h0);
    check("err_nstb", nstb, 1);
    finish_rsp();
    // ack beats err and rty
    mode = 4; rd_dat = 32'hA5A5A5A5;
    xfer(1'b0, 32'h0000001C, 4'hF, 32'h0, 20);
    check("prio_ack_err", {31'd0, rsp_err_o}, 32'd0); check("prio_ack_dat", rsp_dat_o, 32'hA5A5A5A5);
    finish_rsp();
    // err beats rty (no retry)
    mode = 5;
    xfer(1'b0, 32'h00000020, 4'hF, 32'h0, 20);
    check("prio_err_err", {31'd0, rsp_err_o}, 32'd1); check("prio_err_nstb", nstb, 1);
    check("prio_err_lat", lat, 1);
    finish_rsp();
    // Response backpressure with a competing request pending
    mode = 0; rd_dat = 32'h0BADCAFE;
    xfer(1'b0, 32'h00000024, 4'hF, 32'h0, 20);
    req_valid_i = 1'b1; req_adr_i = 32'h00000028; req_we_i = 1'b0;
    hold_bad = 1'b0;
    repeat (5) begin
      tick();
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'h0BADCAFE || req_ready_o !== 1'b0 || cyc_o !== 1'b0)
        hold_bad = 1'b1;
    end
    check("bp_stable", {31'd0, hold_bad}, 32'd0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("bp_no_same_cycle", {31'd0, cyc_o}, 32'd0);
    check("bp_ready_after", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b0;
    tick();
`ifdef WB_INITIATOR_TIMEOUT_EN
    // Bus timeout
    mode = 3;
    xfer(1'b0, 32'h00000030, 4'hF, 32'h0, 50);
    check("tmo_lat", lat, 10); check("tmo_stbcyc", stb_cyc, 10);
    check("tmo_err", {31'd0, rsp_err_o}, 32'd1); check("tmo_flag", {31'd0, rsp_timeout_o}, 32'd1);
    check("tmo_dat", rsp_dat_o, 32'h0);
    finish_rsp();
`endif
    // Reset mid-transfer
    mode = 3; nstb = 0; stb_cyc = 0;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h00000040; req_sel_i = 4'hF;
    tick();
    req_valid_i = 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
    repeat (3) tick();
`else
    repeat (20) tick();
    check("no_tmo_stbcyc", stb_cyc, 21);
`endif
    check("stb_before_rst", {31'd0, stb_o}, 32'd1);
    check("no_rsp_before_rst", {31'd0, rsp_valid_o}, 32'd0);
    #2 rst_ni = 1'b0;
    #1;
    check("async_cyc", {31'd0, cyc_o}, 32'd0);
    check("async_stb", {31'd0, stb_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("rst_ready_after", {31'd0, req_ready_o}, 32'd1);
    check("rst_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
